// File: rtl/cgra_pkg.sv
// Shared types for the CGRA job sequencer slice.
//   job_desc_t  : one DMA/compute job descriptor (source, destination, byte size)
//   seq_state_e : sequencer FSM state encoding
package cgra_pkg;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] size;
  } job_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    DMA_GO,
    DMA_WAIT,
    CU_GO,
    CU_WAIT,
    DONE
  } seq_state_e;

endpackage

// File: rtl/cgra_job_fifo.sv
// Synchronous descriptor FIFO for the CGRA job sequencer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of all entries (wins over push/pop)
//   push, push_data   : write one descriptor when not full
//   pop, pop_data     : pop_data shows the head entry; pop removes it when not empty
//   full, empty       : occupancy flags
//   level             : current entry count, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module cgra_job_fifo
  import cgra_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  job_desc_t                push_data,
  input  logic                     pop,
  output job_desc_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  job_desc_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cgra_job_sequencer.sv
// CGRA job sequencer: queues job descriptors and runs each as a DMA phase
// followed by a compute-unit phase, one job at a time, in push order.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   job_valid/job_ready, job_src/dst/size : descriptor push handshake
//   dma_src/dst/size                 : descriptor of the active job
//   dma_start, dma_busy_i, dma_done_i: DMA kick pulse / status / completion pulse
//   cu_start, cu_busy_i, cu_done_i   : compute kick pulse / status / completion pulse
//   abort_i                          : flush queue and drop the active job
//   idle, job_done, job_err          : status and completion/error pulses
//   jobs_done_cnt                    : wrapping count of completed jobs
//   fifo_level                       : queued descriptor count
// Optional feature macro CGRA_SEQ_TIMEOUT_EN: per-phase watchdog of
// TIMEOUT_CYCLES cycles in DMA_WAIT/CU_WAIT; expiry drops the active job
// with a job_err pulse but keeps the queue.
module cgra_job_sequencer
  import cgra_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [31:0]                   job_src,
  input  logic [31:0]                   job_dst,
  input  logic [31:0]                   job_size,
  output logic [31:0]                   dma_src,
  output logic [31:0]                   dma_dst,
  output logic [31:0]                   dma_size,
  output logic                          dma_start,
  input  logic                          dma_busy_i,
  input  logic                          dma_done_i,
  output logic                          cu_start,
  input  logic                          cu_busy_i,
  input  logic                          cu_done_i,
  input  logic                          abort_i,
  output logic                          idle,
  output logic                          job_done,
  output logic                          job_err,
  output logic [15:0]                   jobs_done_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  seq_state_e state_q, state_d;
  job_desc_t  active_q;
  job_desc_t  head;
  job_desc_t  push_desc;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       tmo_hit;
  logic       tmo_err;

  // Busy inputs are status only; sequencing is driven by the done pulses.
  logic unused_busy;
  assign unused_busy = &{1'b0, dma_busy_i, cu_busy_i};

  assign push_desc = '{src: job_src, dst: job_dst, size: job_size};
  assign job_ready = !fifo_full && !abort_i;
  assign idle      = (state_q == IDLE) && fifo_empty;
  assign dma_src   = active_q.src;
  assign dma_dst   = active_q.dst;
  assign dma_size  = active_q.size;

  cgra_job_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_i),
    .push      (job_valid && job_ready),
    .push_data (push_desc),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef CGRA_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  // Any state change restarts the count, so it is zero on entry to a WAIT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (state_q == DMA_WAIT || state_q == CU_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    dma_start = 1'b0;
    cu_start  = 1'b0;
    job_done  = 1'b0;
    tmo_err   = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DMA_GO;
          end
        end
        DMA_GO: begin
          if (active_q.size == '0) begin
            state_d = CU_GO;
          end else begin
            dma_start = 1'b1;
            state_d   = DMA_WAIT;
          end
        end
        DMA_WAIT: begin
          if (dma_done_i) begin
            state_d = CU_GO;
          end else if (tmo_hit) begin
            tmo_err = 1'b1;
            state_d = IDLE;
          end
        end
        CU_GO: begin
          cu_start = 1'b1;
          state_d  = CU_WAIT;
        end
        CU_WAIT: begin
          if (cu_done_i) begin
            state_d = DONE;
          end else if (tmo_hit) begin
            tmo_err = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          job_done = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      active_q      <= '0;
      jobs_done_cnt <= '0;
      job_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) active_q <= head;
      if (job_done) jobs_done_cnt <= jobs_done_cnt + 16'd1;
      job_err <= (abort_i && state_q != IDLE) || tmo_err;
    end
  end

endmodule
